// File: rtl/ifetch_unit.sv
// Instruction fetch unit: 2-deep in-order fetch buffer, up to 2 outstanding memory requests, redirect with stale-response discard.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_fault and halt fetch.
module ifetch_unit #(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [Width-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [Width-1:0] inst_pc,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic             fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [Width-1:0] fetch_pc_q, fetch_pc_d;
  logic [Width-1:0] resp_pc_q, resp_pc_d;
  logic [1:0]       outst_q, outst_d;
  logic [1:0]       discard_q, discard_d;
  logic [1:0]       count_q, count_d;
  logic [31:0]      buf_inst_q [2];
  logic [31:0]      buf_inst_d [2];
  logic [Width-1:0] buf_pc_q [2];
  logic [Width-1:0] buf_pc_d [2];
  logic             fault_q, fault_d;
  logic [Width-1:0] target_pc;
  logic             misaligned;
  logic             grant, pop, push;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target_pc  = redirect_pc;
  assign misaligned = |redirect_pc[1:0];
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign target_pc  = {redirect_pc[Width-1:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  // Gated by rst_n so the first request appears as soon as reset releases.
  assign imem_req    = rst_n & ~redirect_valid & ~fault_q &
                       (({1'b0, outst_q} + {1'b0, count_q}) < 3'd2);
  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = (count_q != 2'd0);
  assign inst        = inst_valid ? buf_inst_q[0] : NOP;
  assign inst_pc     = buf_pc_q[0];
  assign fetch_fault = fault_q;

  assign grant = imem_req & imem_gnt;
  assign pop   = inst_valid & inst_ready;
  assign push  = imem_rvalid & ~redirect_valid & (discard_q == 2'd0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    discard_d  = discard_q;
    fault_d    = fault_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    outst_d    = outst_q + {1'b0, grant} - {1'b0, imem_rvalid};
    if (grant)
      fetch_pc_d = fetch_pc_q + Width'(4);
    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old stream.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      count_d    = 2'd0;
      discard_d  = outst_d;
      fault_d    = misaligned;
    end else begin
      if (imem_rvalid && discard_q != 2'd0)
        discard_d = discard_q - 2'd1;
      if (push)
        resp_pc_d = resp_pc_q + Width'(4);
      case ({pop, push})
        2'b10: begin
          buf_inst_d[0] = buf_inst_q[1];
          buf_pc_d[0]   = buf_pc_q[1];
          count_d       = count_q - 2'd1;
        end
        2'b01: begin
          buf_inst_d[count_q[0]] = imem_rdata;
          buf_pc_d[count_q[0]]   = resp_pc_q;
          count_d                = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            buf_inst_d[0] = buf_inst_q[1];
            buf_pc_d[0]   = buf_pc_q[1];
            buf_inst_d[1] = imem_rdata;
            buf_pc_d[1]   = resp_pc_q;
          end else begin
            buf_inst_d[0] = imem_rdata;
            buf_pc_d[0]   = resp_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= 2'd0;
      discard_q  <= 2'd0;
      count_q    <= 2'd0;
      fault_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit: memory responder model plus one task per scenario.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic        hold_resp;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] pend_q[$];
  logic [31:0] gnt_q[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_inst[$];

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory returns {addr[15:0], 16'h0013} for each address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  // Record grants and accepted instructions on the active edge (pre-update values)
  initial forever begin
    @(posedge clk);
    if (rst_n && imem_req && imem_gnt) begin
      pend_q.push_back(imem_addr);
      gnt_q.push_back(imem_addr);
    end
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      acc_pc.push_back(inst_pc);
      acc_inst.push_back(inst);
      $display("accept pc=%08h inst=%08h", inst_pc, inst);
    end
  end

  // Responder: one response per cycle, at least one cycle after its grant
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_q.delete();
        imem_rvalid = 1'b0;
      end else if (!hold_resp && pend_q.size() > 0) begin
        imem_rdata  = mem_word(pend_q.pop_front());
        imem_rvalid = 1'b1;
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_redirect(input logic [31:0] pc);
    @(negedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    acc_pc.delete(); acc_inst.delete(); gnt_q.delete();
    @(negedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 200 && acc_pc.size() < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got=%08h exp=0", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (inst !== 32'h13) begin n_bad++; $display("FAIL rst_inst got=%08h exp=00000013", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got=%08h exp=0", inst_pc); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got=%b exp=0", fetch_fault); end
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_addr got=%08h exp=0", imem_addr); end
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    wait_acc(4);
    n_cmp++; if (acc_pc.size() < 4) begin n_bad++; $display("FAIL stream_count got=%0d exp>=4", acc_pc.size()); end
    for (int i = 0; i < 4 && i < acc_pc.size(); i++) begin
      exp = 32'(i * 4);
      n_cmp++; if (acc_pc[i] !== exp) begin n_bad++; $display("FAIL stream_pc[%0d] got=%08h exp=%08h", i, acc_pc[i], exp); end
      n_cmp++; if (acc_inst[i] !== mem_word(exp)) begin n_bad++; $display("FAIL stream_inst[%0d] got=%08h exp=%08h", i, acc_inst[i], mem_word(exp)); end
      n_cmp++; if (gnt_q[i] !== exp) begin n_bad++; $display("FAIL stream_addr[%0d] got=%08h exp=%08h", i, gnt_q[i], exp); end
    end
  endtask

  task automatic test_backpressure;
    inst_ready = 1'b0;
    do_redirect(32'h40);
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got=%b exp=1", inst_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req got=%b exp=0", imem_req); end
    n_cmp++; if (inst_pc !== 32'h40) begin n_bad++; $display("FAIL bp_head_pc got=%08h exp=00000040", inst_pc); end
    n_cmp++; if (inst !== mem_word(32'h40)) begin n_bad++; $display("FAIL bp_head_inst got=%08h exp=%08h", inst, mem_word(32'h40)); end
    n_cmp++; if (gnt_q.size() != 2) begin n_bad++; $display("FAIL bp_grants got=%0d exp=2", gnt_q.size()); end
    inst_ready = 1'b1;
    wait_acc(3);
    n_cmp++; if (acc_pc.size() < 3) begin n_bad++; $display("FAIL bp_count got=%0d exp>=3", acc_pc.size()); end
    for (int i = 0; i < 3 && i < acc_pc.size(); i++) begin
      n_cmp++; if (acc_pc[i] !== 32'h40 + 32'(i * 4)) begin n_bad++; $display("FAIL bp_order[%0d] got=%08h exp=%08h", i, acc_pc[i], 32'h40 + 32'(i * 4)); end
    end
  endtask

  task automatic test_redirect_stale;
    hold_resp = 1'b1;
    do_redirect(32'h80);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stale_limit_req got=%b exp=0", imem_req); end
    do_redirect(32'h100);
    hold_resp = 1'b0;
    wait_acc(2);
    n_cmp++; if (acc_pc.size() < 2) begin n_bad++; $display("FAIL stale_count got=%0d exp>=2", acc_pc.size()); end
    else begin
      n_cmp++; if (acc_pc[0] !== 32'h100) begin n_bad++; $display("FAIL stale_pc0 got=%08h exp=00000100", acc_pc[0]); end
      n_cmp++; if (acc_inst[0] !== mem_word(32'h100)) begin n_bad++; $display("FAIL stale_inst0 got=%08h exp=%08h", acc_inst[0], mem_word(32'h100)); end
      n_cmp++; if (acc_pc[1] !== 32'h104) begin n_bad++; $display("FAIL stale_pc1 got=%08h exp=00000104", acc_pc[1]); end
    end
  endtask

  task automatic test_redirect_same_cycle;
    bit found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk); #1;
      if (imem_rvalid && inst_valid) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL same_cycle_setup got=none exp=rvalid&valid"); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    acc_pc.delete(); acc_inst.delete(); gnt_q.delete();
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL same_cycle_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (inst !== 32'h13) begin n_bad++; $display("FAIL same_cycle_nop got=%08h exp=00000013", inst); end
    wait_acc(1);
    n_cmp++; if (acc_pc.size() < 1) begin n_bad++; $display("FAIL same_cycle_count got=0 exp>=1"); end
    else begin
      n_cmp++; if (acc_pc[0] !== 32'h300) begin n_bad++; $display("FAIL same_cycle_pc got=%08h exp=00000300", acc_pc[0]); end
      n_cmp++; if (acc_inst[0] !== mem_word(32'h300)) begin n_bad++; $display("FAIL same_cycle_inst got=%08h exp=%08h", acc_inst[0], mem_word(32'h300)); end
    end
  endtask

  task automatic test_wrap;
    do_redirect(32'hFFFF_FFFC);
    wait_acc(2);
    n_cmp++; if (acc_pc.size() < 2) begin n_bad++; $display("FAIL wrap_count got=%0d exp>=2", acc_pc.size()); end
    else begin
      n_cmp++; if (acc_pc[0] !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc0 got=%08h exp=fffffffc", acc_pc[0]); end
      n_cmp++; if (acc_pc[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_pc1 got=%08h exp=00000000", acc_pc[1]); end
      n_cmp++; if (gnt_q[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got=%08h exp=00000000", gnt_q[1]); end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    acc_pc.delete(); acc_inst.delete(); gnt_q.delete();
    @(negedge clk); #1;
    redirect_pc = 32'h600;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    wait_acc(2);
    n_cmp++; if (acc_pc.size() < 2) begin n_bad++; $display("FAIL b2b_count got=%0d exp>=2", acc_pc.size()); end
    else begin
      n_cmp++; if (acc_pc[0] !== 32'h600) begin n_bad++; $display("FAIL b2b_pc0 got=%08h exp=00000600", acc_pc[0]); end
      n_cmp++; if (acc_pc[1] !== 32'h604) begin n_bad++; $display("FAIL b2b_pc1 got=%08h exp=00000604", acc_pc[1]); end
      n_cmp++; if (gnt_q[0] !== 32'h600) begin n_bad++; $display("FAIL b2b_first_addr got=%08h exp=00000600", gnt_q[0]); end
    end
  endtask

  task automatic test_align;
    do_redirect(32'h102);
`ifdef IFETCH_ALIGN_CHECK_EN
    n_cmp++; if (fetch_fault !== 1'b1) begin n_bad++; $display("FAIL align_fault got=%b exp=1", fetch_fault); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL align_req got=%b exp=0", imem_req); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (gnt_q.size() != 0) begin n_bad++; $display("FAIL align_halt got=%0d grants exp=0", gnt_q.size()); end
    n_cmp++; if (fetch_fault !== 1'b1) begin n_bad++; $display("FAIL align_sticky got=%b exp=1", fetch_fault); end
    do_redirect(32'h200);
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL align_clear got=%b exp=0", fetch_fault); end
    wait_acc(1);
    n_cmp++; if (acc_pc.size() < 1 || acc_pc[0] !== 32'h200) begin n_bad++; $display("FAIL align_resume got=%0d entries exp pc 00000200", acc_pc.size()); end
`else
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL align_fault got=%b exp=0", fetch_fault); end
    wait_acc(1);
    n_cmp++; if (acc_pc.size() < 1) begin n_bad++; $display("FAIL align_count got=0 exp>=1"); end
    else begin
      n_cmp++; if (acc_pc[0] !== 32'h100) begin n_bad++; $display("FAIL align_forced_pc got=%08h exp=00000100", acc_pc[0]); end
      n_cmp++; if (acc_inst[0] !== mem_word(32'h100)) begin n_bad++; $display("FAIL align_inst got=%08h exp=%08h", acc_inst[0], mem_word(32'h100)); end
    end
`endif
  endtask

  task automatic test_mid_reset;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mrst_req got=%b exp=0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL mrst_addr got=%08h exp=0", imem_addr); end
    n_cmp++; if (inst !== 32'h13) begin n_bad++; $display("FAIL mrst_inst got=%08h exp=00000013", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL mrst_pc got=%08h exp=0", inst_pc); end
    acc_pc.delete(); acc_inst.delete(); gnt_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_acc(2);
    n_cmp++; if (acc_pc.size() < 2) begin n_bad++; $display("FAIL mrst_count got=%0d exp>=2", acc_pc.size()); end
    else begin
      n_cmp++; if (acc_pc[0] !== 32'h0) begin n_bad++; $display("FAIL mrst_pc0 got=%08h exp=0", acc_pc[0]); end
      n_cmp++; if (acc_inst[0] !== mem_word(32'h0)) begin n_bad++; $display("FAIL mrst_inst0 got=%08h exp=%08h", acc_inst[0], mem_word(32'h0)); end
      n_cmp++; if (acc_pc[1] !== 32'h4) begin n_bad++; $display("FAIL mrst_pc1 got=%08h exp=00000004", acc_pc[1]); end
    end
  endtask

  initial begin
    imem_gnt       = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    hold_resp      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_same_cycle();
    test_wrap();
    test_back_to_back();
    test_align();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
